adc_capture: RTL and testbench

Receive-side counterpart of the sweep DAC path. Drives the ADC sample clock and captures 14-bit offset-binary samples of the swept tone after it returns through the analog path under test. Re-emits the accepted samples as a strobed stream and reports per-window max/min/peak-to-peak for sweep frequency-response measurement. `sweep_sync` pulses from the sweep controller realign windowing to each frequency step.

---
 rtl/adc_capture.sv | 175 +++++++++++++++++
 tb/tb_adc_capture.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_capture.sv
// ADC capture front end: generates the ADC sample clock, captures samples, and
// reports per-window max/min/peak-to-peak, realigned by sweep_sync pulses.
module adc_capture #(
   parameter int CLK_DIV    = 4,
   parameter int PIPE_DLY   = 8,
   parameter int SETTLE_LEN = 16,
   parameter int WIN_LEN    = 1024
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   input  logic [13:0] ad_data,
   input  logic        ad_otr,
   input  logic        sweep_sync,
   output logic        ad_clk,
   output logic        smp_valid,
   output logic [13:0] smp_data,
   output logic        amp_valid,
   output logic [13:0] amp_max,
   output logic [13:0] amp_min,
   output logic [13:0] amp_vpp,
   output logic        amp_ovr,
   output logic [15:0] win_idx
);

   localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
   localparam logic [DIV_W-1:0] CAP_CNT  = DIV_W'(CLK_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

   localparam logic [15:0] PIPE_LAST   = 16'((PIPE_DLY > 0) ? PIPE_DLY - 1 : 0);
   localparam logic [15:0] SETTLE_LAST = 16'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);
   localparam logic [15:0] WIN_LAST    = 16'(WIN_LEN - 1);

   typedef enum logic [1:0] {
      ST_FLUSH,
      ST_SETTLE,
      ST_ACQ
   } state_t;

   // A zero-length discard phase collapses straight into acquisition.
   localparam state_t RESET_STATE = (PIPE_DLY == 0) ? ST_ACQ : ST_FLUSH;
   localparam state_t SYNC_STATE  = (SETTLE_LEN == 0) ? ST_ACQ : ST_SETTLE;

   logic [DIV_W-1:0] div_cnt;
   logic [DIV_W-1:0] div_nxt;
   logic             cap_edge;

   state_t      state;
   state_t      state_nxt;
   logic [15:0] scnt;
   logic [15:0] scnt_nxt;
   logic        accept;
   logic        win_end;

   logic [13:0] run_max;
   logic [13:0] run_min;
   logic        run_ovr;
   logic        win_done;

   always_comb begin
      div_nxt  = (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_ONE;
      cap_edge = (div_cnt == CAP_CNT);
   end

   // ad_clk is registered from the next divider value so it lines up with div_cnt.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         div_cnt <= '0;
         ad_clk  <= 1'b0;
      end else begin
         div_cnt <= div_nxt;
         ad_clk  <= (div_nxt >= DIV_HALF);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= RESET_STATE;
         scnt  <= '0;
      end else begin
         state <= state_nxt;
         scnt  <= scnt_nxt;
      end
   end

   // Sync takes priority over a coincident capture edge, so that sample is dropped.
   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      accept    = 1'b0;
      win_end   = 1'b0;
      if (sweep_sync) begin
         state_nxt = SYNC_STATE;
         scnt_nxt  = '0;
      end else if (cap_edge) begin
         case (state)
            ST_FLUSH: begin
               if (scnt == PIPE_LAST) begin
                  state_nxt = ST_ACQ;
                  scnt_nxt  = '0;
               end else begin
                  scnt_nxt = scnt + 16'd1;
               end
            end
            ST_SETTLE: begin
               if (scnt == SETTLE_LAST) begin
                  state_nxt = ST_ACQ;
                  scnt_nxt  = '0;
               end else begin
                  scnt_nxt = scnt + 16'd1;
               end
            end
            ST_ACQ: begin
               accept = 1'b1;
               if (scnt == WIN_LAST) begin
                  win_end  = 1'b1;
                  scnt_nxt = '0;
               end else begin
                  scnt_nxt = scnt + 16'd1;
               end
            end
            default: begin
               state_nxt = RESET_STATE;
               scnt_nxt  = '0;
            end
         endcase
      end
   end

   // Window results are published one cycle after the final sample's strobe.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         smp_valid <= 1'b0;
         smp_data  <= '0;
         run_max   <= '0;
         run_min   <= '0;
         run_ovr   <= 1'b0;
         win_done  <= 1'b0;
         amp_valid <= 1'b0;
         amp_max   <= '0;
         amp_min   <= '0;
         amp_vpp   <= '0;
         amp_ovr   <= 1'b0;
         win_idx   <= '0;
      end else begin
         smp_valid <= accept;
         win_done  <= win_end;
         amp_valid <= 1'b0;
         if (accept) begin
            smp_data <= ad_data;
            if (scnt == 16'd0) begin
               run_max <= ad_data;
               run_min <= ad_data;
               run_ovr <= ad_otr;
            end else begin
               if (ad_data > run_max) run_max <= ad_data;
               if (ad_data < run_min) run_min <= ad_data;
               run_ovr <= run_ovr | ad_otr;
            end
         end
         if (sweep_sync) begin
            win_idx <= '0;
         end else if (win_done) begin
            amp_valid <= 1'b1;
            amp_max   <= run_max;
            amp_min   <= run_min;
            amp_vpp   <= run_max - run_min;
            amp_ovr   <= run_ovr;
            win_idx   <= win_idx + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture with CLK_DIV=4, PIPE_DLY=8, SETTLE_LEN=16, WIN_LEN=8:
// table of windows with hand-computed results, plus sync and reset sequences.
module tb_adc_capture;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [13:0] ad_data;
   logic        ad_otr;
   logic        sweep_sync;
   logic        ad_clk;
   logic        smp_valid;
   logic [13:0] smp_data;
   logic        amp_valid;
   logic [13:0] amp_max;
   logic [13:0] amp_min;
   logic [13:0] amp_vpp;
   logic        amp_ovr;
   logic [15:0] win_idx;

   int errors;
   int checks;

   typedef struct {
      logic [13:0] d [8];
      logic [7:0]  otr;
      logic [13:0] emax;
      logic [13:0] emin;
      logic [13:0] evpp;
      logic        eovr;
      logic [15:0] eidx;
   } win_vec_t;

   localparam int NUM_TABLE = 5;
   win_vec_t vecs [8];

   // Independent sample-phase counter: a capture edge is the one that leaves phase at 2.
   logic [1:0] phase;

   adc_capture #(
      .CLK_DIV(4),
      .PIPE_DLY(8),
      .SETTLE_LEN(16),
      .WIN_LEN(8)
   ) dut (
      .sys_clk(sys_clk),
      .sys_rst_n(sys_rst_n),
      .ad_data(ad_data),
      .ad_otr(ad_otr),
      .sweep_sync(sweep_sync),
      .ad_clk(ad_clk),
      .smp_valid(smp_valid),
      .smp_data(smp_data),
      .amp_valid(amp_valid),
      .amp_max(amp_max),
      .amp_min(amp_min),
      .amp_vpp(amp_vpp),
      .amp_ovr(amp_ovr),
      .win_idx(win_idx)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) phase <= 2'd0;
      else            phase <= phase + 2'd1;
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ad_clk"}, 32'(ad_clk), 0);
      checkOutput({tag, "_smp_valid"}, 32'(smp_valid), 0);
      checkOutput({tag, "_amp_valid"}, 32'(amp_valid), 0);
      checkOutput({tag, "_amp_ovr"}, 32'(amp_ovr), 0);
      checkOutput({tag, "_smp_data"}, 32'(smp_data), 0);
      checkOutput({tag, "_amp_max"}, 32'(amp_max), 0);
      checkOutput({tag, "_amp_min"}, 32'(amp_min), 0);
      checkOutput({tag, "_amp_vpp"}, 32'(amp_vpp), 0);
      checkOutput({tag, "_win_idx"}, 32'(win_idx), 0);
   endtask

   // Presents one sample and returns #1 after the capture edge that takes it.
   task automatic applyStimulus(input logic [13:0] d, input logic o, input logic s);
      bit got;
      got = 1'b0;
      @(negedge sys_clk);
      ad_data = d;
      ad_otr  = o;
      for (int k = 0; k < 8; k++) begin
         if (phase == 2'd1) sweep_sync = s;
         @(posedge sys_clk);
         #1;
         sweep_sync = 1'b0;
         if (phase == 2'd2) begin
            got = 1'b1;
            break;
         end
         @(negedge sys_clk);
      end
      if (!got) checkOutput("capture_timeout", 0, 1);
   endtask

   task automatic runWindow(input int k);
      for (int i = 0; i < 8; i++) begin
         applyStimulus(vecs[k].d[i], vecs[k].otr[i], 1'b0);
         checkOutput("win_smp_valid", 32'(smp_valid), 1);
         checkOutput("win_smp_data", 32'(smp_data), 32'(vecs[k].d[i]));
         checkOutput("win_amp_early", 32'(amp_valid), 0);
      end
      @(posedge sys_clk);
      #1;
      checkOutput("amp_valid", 32'(amp_valid), 1);
      checkOutput("amp_max", 32'(amp_max), 32'(vecs[k].emax));
      checkOutput("amp_min", 32'(amp_min), 32'(vecs[k].emin));
      checkOutput("amp_vpp", 32'(amp_vpp), 32'(vecs[k].evpp));
      checkOutput("amp_ovr", 32'(amp_ovr), 32'(vecs[k].eovr));
      checkOutput("win_idx", 32'(win_idx), 32'(vecs[k].eidx));
      checkOutput("smp_valid_pulse", 32'(smp_valid), 0);
      @(posedge sys_clk);
      #1;
      checkOutput("amp_valid_pulse", 32'(amp_valid), 0);
      checkOutput("amp_max_held", 32'(amp_max), 32'(vecs[k].emax));
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] clk_pat;
      errors     = 0;
      checks     = 0;
      sys_rst_n  = 1'b0;
      ad_data    = '0;
      ad_otr     = 1'b0;
      sweep_sync = 1'b0;
      clk_pat    = 8'b1100_1100;

      vecs[0].d = '{14'd8, 14'd9, 14'd10, 14'd11, 14'd12, 14'd13, 14'd14, 14'd15};
      vecs[0].otr = 8'h00; vecs[0].emax = 14'd15; vecs[0].emin = 14'd8;
      vecs[0].evpp = 14'd7; vecs[0].eovr = 1'b0; vecs[0].eidx = 16'd1;
      vecs[1].d = '{14'd100, 14'd3000, 14'd50, 14'd16000, 14'd7, 14'd8000, 14'd200, 14'd9};
      vecs[1].otr = 8'b0000_1000; vecs[1].emax = 14'd16000; vecs[1].emin = 14'd7;
      vecs[1].evpp = 14'd15993; vecs[1].eovr = 1'b1; vecs[1].eidx = 16'd2;
      vecs[2].d = '{14'h1000, 14'h3FFF, 14'h2000, 14'h0000, 14'h0001, 14'h3FFE, 14'd5, 14'd6};
      vecs[2].otr = 8'h00; vecs[2].emax = 14'd16383; vecs[2].emin = 14'd0;
      vecs[2].evpp = 14'd16383; vecs[2].eovr = 1'b0; vecs[2].eidx = 16'd3;
      vecs[3].d = '{14'd341, 14'd341, 14'd341, 14'd341, 14'd341, 14'd341, 14'd341, 14'd341};
      vecs[3].otr = 8'h00; vecs[3].emax = 14'd341; vecs[3].emin = 14'd341;
      vecs[3].evpp = 14'd0; vecs[3].eovr = 1'b0; vecs[3].eidx = 16'd4;
      vecs[4].d = '{14'd9000, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5, 14'd6, 14'd7000};
      vecs[4].otr = 8'b1000_0000; vecs[4].emax = 14'd9000; vecs[4].emin = 14'd1;
      vecs[4].evpp = 14'd8999; vecs[4].eovr = 1'b1; vecs[4].eidx = 16'd5;
      vecs[5].d = '{14'd20, 14'd40, 14'd60, 14'd80, 14'd100, 14'd120, 14'd140, 14'd160};
      vecs[5].otr = 8'h00; vecs[5].emax = 14'd160; vecs[5].emin = 14'd20;
      vecs[5].evpp = 14'd140; vecs[5].eovr = 1'b0; vecs[5].eidx = 16'd1;
      vecs[6].d = '{14'd500, 14'd400, 14'd300, 14'd200, 14'd100, 14'd50, 14'd25, 14'd12};
      vecs[6].otr = 8'h00; vecs[6].emax = 14'd500; vecs[6].emin = 14'd12;
      vecs[6].evpp = 14'd488; vecs[6].eovr = 1'b0; vecs[6].eidx = 16'd1;
      vecs[7].d = '{14'd8191, 14'd8192, 14'd8190, 14'd8193, 14'd1, 14'd16383, 14'd2, 14'd3};
      vecs[7].otr = 8'b0000_0001; vecs[7].emax = 14'd16383; vecs[7].emin = 14'd1;
      vecs[7].evpp = 14'd16382; vecs[7].eovr = 1'b1; vecs[7].eidx = 16'd1;

      repeat (3) @(negedge sys_clk);
      checkResetOutputs("por");
      sys_rst_n = 1'b1;

      $display("[TB] ad_clk waveform and pipeline flush");
      for (int c = 0; c < 8; c++) begin
         ad_data = 14'(c / 4);
         checkOutput("ad_clk", 32'(ad_clk), 32'(clk_pat[c]));
         @(negedge sys_clk);
      end
      for (int n = 2; n < 8; n++) begin
         applyStimulus(14'(n), 1'b0, 1'b0);
         checkOutput("flush_no_smp", 32'(smp_valid), 0);
      end

      $display("[TB] window table");
      for (int k = 0; k < NUM_TABLE; k++) runWindow(k);

      $display("[TB] sweep_sync mid-window");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(14'(1000 + i), 1'b0, 1'b0);
         checkOutput("pre_sync_smp", 32'(smp_valid), 1);
      end
      @(negedge sys_clk);
      sweep_sync = 1'b1;
      @(posedge sys_clk);
      #1;
      sweep_sync = 1'b0;
      checkOutput("sync_idx_clear", 32'(win_idx), 0);
      checkOutput("sync_amp_held", 32'(amp_max), 9000);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(14'(2000 + i), 1'b0, 1'b0);
         checkOutput("settle_no_smp", 32'(smp_valid), 0);
         checkOutput("settle_no_amp", 32'(amp_valid), 0);
      end
      runWindow(5);

      $display("[TB] sweep_sync on final capture edge");
      for (int i = 0; i < 7; i++) begin
         applyStimulus(14'(3000 + i), 1'b0, 1'b0);
         checkOutput("pre_coll_smp", 32'(smp_valid), 1);
      end
      applyStimulus(14'd3007, 1'b0, 1'b1);
      checkOutput("coll_no_smp", 32'(smp_valid), 0);
      checkOutput("coll_idx_clear", 32'(win_idx), 0);
      @(posedge sys_clk);
      #1;
      checkOutput("coll_no_amp", 32'(amp_valid), 0);
      for (int i = 0; i < 16; i++) begin
         applyStimulus(14'(4000 + i), 1'b0, 1'b0);
         checkOutput("coll_settle_no_smp", 32'(smp_valid), 0);
      end
      runWindow(6);

      $display("[TB] reset mid-window");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(14'(5000 + i), 1'b1, 1'b0);
         checkOutput("pre_rst_smp", 32'(smp_valid), 1);
      end
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      checkResetOutputs("async_rst");
      repeat (3) @(negedge sys_clk);
      checkResetOutputs("rst_hold");
      sys_rst_n = 1'b1;
      for (int n = 0; n < 8; n++) begin
         applyStimulus(14'(6000 + n), 1'b0, 1'b0);
         checkOutput("reflush_no_smp", 32'(smp_valid), 0);
         checkOutput("reflush_idx", 32'(win_idx), 0);
      end
      runWindow(7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
